// File: rtl/mitm_session_controller.sv
// -----------------------------------------------------------------------------
// mitm_session_controller
//
// Glue between the two UART receivers/transmitters and the mode-select button
// of the UART man-in-the-middle top level.
//
//   * Bytes received on if0 are sent out on if1, and bytes received on if1 are
//     sent out on if0. Each byte is forwarded, substituted, dropped or
//     ROT13-encoded according to the active mode.
//   * Owns the one-hot mode register. A mode change requested during a session
//     is deferred until that session ends.
//   * Each direction has a small FIFO and a transmitter handshake FSM.
//   * Tracks session activity (comm_active) using an idle timeout.
//
// Ports:
//   sys_clk, rst              clock, synchronous active-high reset
//   mode_next                 single-cycle pulse requesting the next mode
//   mode_leds                 one-hot active mode
//   comm_active               session in progress
//   overflow                  sticky: a byte was dropped on a full FIFO
//   if0_rx_data/if0_rx_valid  byte strobe from the if0 receiver
//   if1_rx_data/if1_rx_valid  byte strobe from the if1 receiver
//   if0_tx_data/if0_tx_start  byte and start pulse to the if0 transmitter
//   if0_tx_ready              if0 transmitter idle
//   if1_tx_data/if1_tx_start  byte and start pulse to the if1 transmitter
//   if1_tx_ready              if1 transmitter idle
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mitm_direction
//
// One direction of the relay: a FIFO_DEPTH-entry FIFO followed by a
// transmitter handshake FSM. It issues a one-cycle start pulse when the
// transmitter is ready. It then waits for the transmitter to go busy and
// become ready again before it launches the next byte.
//
// Ports:
//   sys_clk, rst     clock, synchronous active-high reset
//   push_valid/data  byte to enqueue (already transformed)
//   push_dropped     pulse: push_valid hit a full FIFO and the byte was lost
//   tx_ready         transmitter idle
//   tx_data/start    byte and one-cycle start pulse to the transmitter
//   fifo_empty       no bytes queued
//   fsm_idle         handshake FSM is in IDLE
// -----------------------------------------------------------------------------
module mitm_direction #(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [NUM_DATA_BITS-1:0] push_data,
    output logic                     push_dropped,
    input  logic                     tx_ready,
    output logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     tx_start,
    output logic                     fifo_empty,
    output logic                     fsm_idle
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    tx_state_t state, state_next;

    logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;
    logic                     full;
    logic                     pop;
    logic                     do_push;

    assign fifo_empty = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign fsm_idle   = (state == TX_IDLE);

    // A full FIFO can still accept a byte when the head is popped on the
    // same edge.
    assign do_push      = push_valid && (!full || pop);
    assign push_dropped = push_valid && full && !pop;

    // Handshake FSM next-state logic. A byte is popped only from IDLE with
    // the transmitter ready. The FSM then sees the transmitter through a full
    // busy period before it returns to IDLE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty && tx_ready) begin
                    pop        = 1'b1;
                    state_next = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (tx_ready) begin
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // State register plus the registered start pulse and data. tx_data keeps
    // the last byte sent until the next pop.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_next;
            tx_start <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    // FIFO storage. It needs no reset because the pointers and count define
    // which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy. The depth is a power of two, so the
    // pointers wrap naturally.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module mitm_session_controller #(
    parameter int                       NUM_DATA_BITS       = 8,
    parameter int                       MODE_WIDTH          = 4,
    parameter int                       FIFO_DEPTH          = 4,
    parameter int                       IDLE_TIMEOUT_CYCLES = 1250,
    parameter logic [NUM_DATA_BITS-1:0] SUB_BYTE            = 8'h3F
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     mode_next,
    output logic [MODE_WIDTH-1:0]    mode_leds,
    output logic                     comm_active,
    output logic                     overflow,
    input  logic [NUM_DATA_BITS-1:0] if0_rx_data,
    input  logic                     if0_rx_valid,
    input  logic [NUM_DATA_BITS-1:0] if1_rx_data,
    input  logic                     if1_rx_valid,
    output logic [NUM_DATA_BITS-1:0] if0_tx_data,
    output logic                     if0_tx_start,
    input  logic                     if0_tx_ready,
    output logic [NUM_DATA_BITS-1:0] if1_tx_data,
    output logic                     if1_tx_start,
    input  logic                     if1_tx_ready
);

    localparam int CW = $clog2(IDLE_TIMEOUT_CYCLES + 1);

    localparam logic [NUM_DATA_BITS-1:0] CH_UP_A = NUM_DATA_BITS'(8'h41);
    localparam logic [NUM_DATA_BITS-1:0] CH_UP_M = NUM_DATA_BITS'(8'h4D);
    localparam logic [NUM_DATA_BITS-1:0] CH_UP_Z = NUM_DATA_BITS'(8'h5A);
    localparam logic [NUM_DATA_BITS-1:0] CH_LO_A = NUM_DATA_BITS'(8'h61);
    localparam logic [NUM_DATA_BITS-1:0] CH_LO_M = NUM_DATA_BITS'(8'h6D);
    localparam logic [NUM_DATA_BITS-1:0] CH_LO_Z = NUM_DATA_BITS'(8'h7A);
    localparam logic [NUM_DATA_BITS-1:0] ROT_AMT = NUM_DATA_BITS'(13);

    typedef enum logic [3:0] {
        MODE_FORWARD     = 4'b0001,
        MODE_SUB0_BLOCK1 = 4'b0010,
        MODE_SUB1_BLOCK0 = 4'b0100,
        MODE_ROT13       = 4'b1000
    } mode_t;

    mode_t                    mode;
    logic                     pending;
    logic [CW-1:0]            idle_cnt;

    logic                     a_valid, b_valid;
    logic [NUM_DATA_BITS-1:0] a_data, b_data;
    logic                     a_dropped, b_dropped;
    logic                     a_empty, b_empty;
    logic                     a_idle, b_idle;
    logic                     any_rx;
    logic                     session_end;

    function automatic mode_t advance(input mode_t m);
        case (m)
            MODE_FORWARD:     return MODE_SUB0_BLOCK1;
            MODE_SUB0_BLOCK1: return MODE_SUB1_BLOCK0;
            MODE_SUB1_BLOCK0: return MODE_ROT13;
            default:          return MODE_FORWARD;
        endcase
    endfunction

    // The first half of each alphabet moves up by 13 and the second half
    // moves down by 13, so the result never leaves its case.
    function automatic logic [NUM_DATA_BITS-1:0] rot13(input logic [NUM_DATA_BITS-1:0] b);
        if (b >= CH_UP_A && b <= CH_UP_Z) begin
            return (b <= CH_UP_M) ? b + ROT_AMT : b - ROT_AMT;
        end else if (b >= CH_LO_A && b <= CH_LO_Z) begin
            return (b <= CH_LO_M) ? b + ROT_AMT : b - ROT_AMT;
        end
        return b;
    endfunction

    assign mode_leds = MODE_WIDTH'(mode);
    assign any_rx    = if0_rx_valid | if1_rx_valid;

    // The session ends once the timeout has expired and both directions have
    // fully drained. This includes a byte that has been popped but whose
    // transmitter has not finished.
    assign session_end = comm_active && (idle_cnt == '0) && a_empty && b_empty
                         && a_idle && b_idle && !any_rx;

    // Per-byte transform selected by the mode register as it stands this
    // cycle. A mode change on the same edge therefore does not affect the
    // byte. FIFO A carries if0 -> if1, and FIFO B carries if1 -> if0.
    always_comb begin
        a_valid = if0_rx_valid;
        a_data  = if0_rx_data;
        b_valid = if1_rx_valid;
        b_data  = if1_rx_data;
        case (mode)
            MODE_SUB0_BLOCK1: begin
                a_data  = SUB_BYTE;
                b_valid = 1'b0;
            end
            MODE_SUB1_BLOCK0: begin
                b_data  = SUB_BYTE;
                a_valid = 1'b0;
            end
            MODE_ROT13: begin
                a_data = rot13(if0_rx_data);
                b_data = rot13(if1_rx_data);
            end
            default: begin
            end
        endcase
    end

    // Session tracking. Every received byte counts as activity and restarts
    // the timeout, including bytes that the mode drops. The counter reaches
    // zero IDLE_TIMEOUT_CYCLES edges after the last byte. comm_active falls on
    // the following edge if nothing is still in flight.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            comm_active <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if (any_rx) begin
                comm_active <= 1'b1;
                idle_cnt    <= CW'(IDLE_TIMEOUT_CYCLES);
            end else begin
                if (idle_cnt != '0) begin
                    idle_cnt <= idle_cnt - 1'b1;
                end
                if (session_end) begin
                    comm_active <= 1'b0;
                end
            end
        end
    end

    // Mode register. Outside a session a press advances the mode immediately.
    // During a session a press is only remembered, and any number of presses
    // collapse into a single advance. That advance is applied on the edge where
    // the session ends. A press on that same edge counts as the remembered one.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mode    <= MODE_FORWARD;
            pending <= 1'b0;
        end else if (session_end) begin
            if (pending || mode_next) begin
                mode <= advance(mode);
            end
            pending <= 1'b0;
        end else if (mode_next) begin
            if (!comm_active) begin
                mode <= advance(mode);
            end else begin
                pending <= 1'b1;
            end
        end
    end

    // The overflow flag is sticky. Once either FIFO drops a byte it stays set
    // until reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (a_dropped || b_dropped) begin
            overflow <= 1'b1;
        end
    end

    mitm_direction #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) u_dir_a (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .push_valid   (a_valid),
        .push_data    (a_data),
        .push_dropped (a_dropped),
        .tx_ready     (if1_tx_ready),
        .tx_data      (if1_tx_data),
        .tx_start     (if1_tx_start),
        .fifo_empty   (a_empty),
        .fsm_idle     (a_idle)
    );

    mitm_direction #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) u_dir_b (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .push_valid   (b_valid),
        .push_data    (b_data),
        .push_dropped (b_dropped),
        .tx_ready     (if0_tx_ready),
        .tx_data      (if0_tx_data),
        .tx_start     (if0_tx_start),
        .fifo_empty   (b_empty),
        .fsm_idle     (b_idle)
    );

endmodule

// File: tb/tb_mitm_session_controller.sv
// -----------------------------------------------------------------------------
// tb_mitm_session_controller
//
// Directed bench for mitm_session_controller. A table of single-byte records
// ({source port, byte, mode, expected output}) covers the per-mode
// transforms. Hand-written sequences cover the following:
//   * start latency
//   * mode deferral
//   * session timeout
//   * FIFO overflow
//   * reset during a transfer
// Each transmitter is modelled as busy for a few cycles after every start
// pulse.
// -----------------------------------------------------------------------------
module tb_mitm_session_controller;

    localparam int TIMEOUT = 1250;
    localparam int BUSY_CYCLES = 6;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       mode_next;
    logic [3:0] mode_leds;
    logic       comm_active;
    logic       overflow;
    logic [7:0] if0_rx_data, if1_rx_data;
    logic       if0_rx_valid, if1_rx_valid;
    logic [7:0] if0_tx_data, if1_tx_data;
    logic       if0_tx_start, if1_tx_start;
    logic       if0_tx_ready, if1_tx_ready;

    int vec_count = 0;
    int miscompares = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int busy0 = 0;
    int busy1 = 0;
    logic hold0 = 1'b0;
    logic hold1 = 1'b0;
    int busy_violations = 0;

    typedef struct {
        logic       src;
        logic [7:0] din;
        logic [3:0] mode;
        logic       sent;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[13];

    mitm_session_controller dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .mode_next    (mode_next),
        .mode_leds    (mode_leds),
        .comm_active  (comm_active),
        .overflow     (overflow),
        .if0_rx_data  (if0_rx_data),
        .if0_rx_valid (if0_rx_valid),
        .if1_rx_data  (if1_rx_data),
        .if1_rx_valid (if1_rx_valid),
        .if0_tx_data  (if0_tx_data),
        .if0_tx_start (if0_tx_start),
        .if0_tx_ready (if0_tx_ready),
        .if1_tx_data  (if1_tx_data),
        .if1_tx_start (if1_tx_start),
        .if1_tx_ready (if1_tx_ready)
    );

    // 10 ns clock
    always #5 sys_clk = ~sys_clk;

    // Transmitter models: ready unless busy sending or held off by the test
    assign if0_tx_ready = (busy0 == 0) && !hold0;
    assign if1_tx_ready = (busy1 == 0) && !hold1;

    // Record every start pulse with its byte and begin a busy period. A start
    // while the model is still busy means the DUT skipped the ready handshake.
    always @(negedge sys_clk) begin
        if (if0_tx_start) begin
            q0.push_back(if0_tx_data);
            if (busy0 != 0) busy_violations++;
            busy0 = BUSY_CYCLES;
        end else if (busy0 > 0) begin
            busy0--;
        end
        if (if1_tx_start) begin
            q1.push_back(if1_tx_data);
            if (busy1 != 0) busy_violations++;
            busy1 = BUSY_CYCLES;
        end else if (busy1 > 0) begin
            busy1--;
        end
    end

    // One comparison: count it, and report it if it misses
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one byte on if0 (src=0) or if1 (src=1) for exactly one edge
    task automatic applyStimulus(input logic src, input logic [7:0] data);
        if (src) begin
            if1_rx_data  = data;
            if1_rx_valid = 1'b1;
        end else begin
            if0_rx_data  = data;
            if0_rx_valid = 1'b1;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        if0_rx_valid = 1'b0;
        if1_rx_valid = 1'b0;
    endtask

    task automatic pressModeNext();
        mode_next = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        mode_next = 1'b0;
    endtask

    // Wait (bounded) for the session to end and return the edges waited
    task automatic waitIdle(input int limit, output int cycles);
        cycles = 0;
        while (comm_active !== 1'b0 && cycles < limit) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            cycles++;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Apply table entries lo..hi: one byte each, then check what came out on
    // each side
    task automatic runVectors(input int lo, input int hi);
        int n_dest;
        int n_other;
        logic [7:0] first;
        for (int i = lo; i <= hi; i++) begin
            q0.delete();
            q1.delete();
            checkOutput($sformatf("vec%0d mode", i), 32'(mode_leds), 32'(vecs[i].mode));
            applyStimulus(vecs[i].src, vecs[i].din);
            idleCycles(20);
            n_dest  = vecs[i].src ? q0.size() : q1.size();
            n_other = vecs[i].src ? q1.size() : q0.size();
            checkOutput($sformatf("vec%0d count", i), 32'(n_dest), vecs[i].sent ? 32'd1 : 32'd0);
            checkOutput($sformatf("vec%0d reverse count", i), 32'(n_other), 32'd0);
            if (n_dest > 0 && vecs[i].sent) begin
                first = vecs[i].src ? q0[0] : q1[0];
                checkOutput($sformatf("vec%0d data", i), 32'(first), 32'(vecs[i].dout));
            end
        end
    endtask

    initial begin
        int cycles;

        //            src   din    mode     sent  dout
        vecs[0]  = '{1'b1, 8'hF1, 4'b0001, 1'b1, 8'hF1};
        vecs[1]  = '{1'b0, 8'h00, 4'b0001, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 8'h9B, 4'b0010, 1'b1, 8'h3F};
        vecs[3]  = '{1'b1, 8'h55, 4'b0010, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'h12, 4'b0100, 1'b1, 8'h3F};
        vecs[5]  = '{1'b0, 8'h77, 4'b0100, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h5A, 4'b1000, 1'b1, 8'h4D};
        vecs[7]  = '{1'b1, 8'h68, 4'b1000, 1'b1, 8'h75};
        vecs[8]  = '{1'b0, 8'h61, 4'b1000, 1'b1, 8'h6E};
        vecs[9]  = '{1'b1, 8'hCA, 4'b1000, 1'b1, 8'hCA};
        vecs[10] = '{1'b0, 8'h7A, 4'b1000, 1'b1, 8'h6D};
        vecs[11] = '{1'b1, 8'h40, 4'b1000, 1'b1, 8'h40};
        vecs[12] = '{1'b0, 8'h4E, 4'b1000, 1'b1, 8'h41};

        rst = 1'b1;
        mode_next = 1'b0;
        if0_rx_data = 8'h00;
        if1_rx_data = 8'h00;
        if0_rx_valid = 1'b0;
        if1_rx_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;

        // Reset state
        checkOutput("reset mode_leds", 32'(mode_leds), 32'h1);
        checkOutput("reset comm_active", 32'(comm_active), 32'h0);
        checkOutput("reset overflow", 32'(overflow), 32'h0);
        checkOutput("reset if0_tx_start", 32'(if0_tx_start), 32'h0);
        checkOutput("reset if1_tx_start", 32'(if1_tx_start), 32'h0);
        checkOutput("reset if1_tx_data", 32'(if1_tx_data), 32'h0);

        // Latency: byte at edge n, start pulse in the cycle after edge n+1
        q1.delete();
        applyStimulus(1'b0, 8'hCA);
        checkOutput("latency start at n", 32'(if1_tx_start), 32'h0);
        checkOutput("latency comm_active", 32'(comm_active), 32'h1);
        @(negedge sys_clk);
        checkOutput("latency start at n+1", 32'(if1_tx_start), 32'h1);
        checkOutput("latency data", 32'(if1_tx_data), 32'hCA);
        @(negedge sys_clk);
        checkOutput("latency single pulse", 32'(if1_tx_start), 32'h0);
        checkOutput("latency data held", 32'(if1_tx_data), 32'hCA);
        idleCycles(20);

        runVectors(0, 1);

        // Press while idle advances immediately
        waitIdle(3 * TIMEOUT, cycles);
        checkOutput("idle before press", 32'(comm_active), 32'h0);
        pressModeNext();
        checkOutput("mode after idle press", 32'(mode_leds), 32'h2);

        runVectors(2, 3);

        // Simultaneous bytes in SUB0_BLOCK1: only the substituted if0 byte goes out
        q0.delete();
        q1.delete();
        if0_rx_data = 8'h38;
        if1_rx_data = 8'h26;
        if0_rx_valid = 1'b1;
        if1_rx_valid = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        if0_rx_valid = 1'b0;
        if1_rx_valid = 1'b0;
        idleCycles(20);
        checkOutput("simul if1 count", 32'(q1.size()), 32'd1);
        if (q1.size() > 0) checkOutput("simul if1 data", 32'(q1[0]), 32'h3F);
        checkOutput("simul if0 count", 32'(q0.size()), 32'd0);

        // Timeout: counter hits zero TIMEOUT edges after the byte, and the flag drops on the next edge
        applyStimulus(1'b0, 8'h20);
        waitIdle(3 * TIMEOUT, cycles);
        checkOutput("session length", 32'(cycles), 32'(TIMEOUT + 1));

        // Two presses mid-session give a single deferred advance
        applyStimulus(1'b0, 8'h11);
        pressModeNext();
        idleCycles(3);
        pressModeNext();
        checkOutput("mode held mid-session", 32'(mode_leds), 32'h2);
        idleCycles(20);
        checkOutput("mode still held", 32'(mode_leds), 32'h2);
        waitIdle(3 * TIMEOUT, cycles);
        checkOutput("deferred session end", 32'(comm_active), 32'h0);
        checkOutput("mode after session", 32'(mode_leds), 32'h4);
        idleCycles(5);
        checkOutput("single advance", 32'(mode_leds), 32'h4);

        runVectors(4, 5);

        // Press together with the byte that opens a session: the mode advances and the byte uses the old mode
        waitIdle(3 * TIMEOUT, cycles);
        checkOutput("idle before combo", 32'(comm_active), 32'h0);
        q0.delete();
        q1.delete();
        mode_next = 1'b1;
        applyStimulus(1'b1, 8'h12);
        mode_next = 1'b0;
        idleCycles(20);
        checkOutput("combo mode", 32'(mode_leds), 32'h8);
        checkOutput("combo count", 32'(q0.size()), 32'd1);
        if (q0.size() > 0) checkOutput("combo data", 32'(q0[0]), 32'h3F);

        runVectors(6, 12);

        // Overflow: six bytes into a four-entry FIFO with the transmitter held off
        checkOutput("overflow before", 32'(overflow), 32'h0);
        q1.delete();
        hold1 = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h10 + 8'(i));
        idleCycles(5);
        checkOutput("overflow set", 32'(overflow), 32'h1);
        checkOutput("no start while held", 32'(q1.size()), 32'd0);
        hold1 = 1'b0;
        idleCycles(80);
        checkOutput("overflow drained count", 32'(q1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (q1.size() > i) checkOutput($sformatf("overflow byte%0d", i), 32'(q1[i]), 32'h10 + 32'(i));
        end
        checkOutput("overflow sticky", 32'(overflow), 32'h1);
        checkOutput("handshake respected", 32'(busy_violations), 32'd0);

        // Reset with three bytes queued discards them
        hold1 = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h30 + 8'(i));
        rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        hold1 = 1'b0;
        q1.delete();
        idleCycles(30);
        checkOutput("post-reset starts", 32'(q1.size()), 32'd0);
        checkOutput("post-reset mode", 32'(mode_leds), 32'h1);
        checkOutput("post-reset overflow", 32'(overflow), 32'h0);
        checkOutput("post-reset comm_active", 32'(comm_active), 32'h0);
        checkOutput("post-reset if1_tx_data", 32'(if1_tx_data), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/mitm_session_controller.md
Name: mitm_session_controller

Overview:
- Sits between the two UART receivers/transmitters and the mode-select logic of the UART MITM top level.
- Routes received bytes from if0 to the if1 transmitter and from if1 to the if0 transmitter. Per byte it forwards, substitutes, drops or ROT13-encodes according to the active mode.
- Owns the mode register. Mode changes are committed only at session boundaries.
- Buffers each direction in a small FIFO, schedules transmitter starts, and generates the comm-active indication.

Parameters:
- NUM_DATA_BITS, 8, UART data width.
- MODE_WIDTH, 4, width of one-hot mode vector (fixed 4 modes).
- FIFO_DEPTH, 4, entries per direction; power of two, >=2.
- IDLE_TIMEOUT_CYCLES, 1250, idle cycles (about 12 bit times at 12 MHz/115200) after the last rx byte before the session ends.
- SUB_BYTE, 8'h3F, replacement byte used in substitute modes.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode_next  in  1  debounced single-cycle pulse requesting the next mode.
- mode_leds  out  MODE_WIDTH  one-hot active mode.
- comm_active  out  1  session in progress.
- overflow  out  1  sticky: a byte was dropped on a full FIFO.
- if0_rx_data  in  NUM_DATA_BITS  byte from the if0 receiver.
- if0_rx_valid  in  1  one-cycle strobe, if0_rx_data valid.
- if1_rx_data  in  NUM_DATA_BITS  byte from the if1 receiver.
- if1_rx_valid  in  1  one-cycle strobe.
- if0_tx_data  out  NUM_DATA_BITS  byte to the if0 transmitter.
- if0_tx_start  out  1  one-cycle start pulse.
- if0_tx_ready  in  1  if0 transmitter idle.
- if1_tx_data  out  NUM_DATA_BITS  byte to the if1 transmitter.
- if1_tx_start  out  1  one-cycle start pulse.
- if1_tx_ready  in  1  if1 transmitter idle.

Behaviour:
- Reset (sync, rst=1 at a sys_clk edge):
  - mode_leds=4'b0001 (FORWARD); comm_active=0; overflow=0.
  - Both tx_start=0 and both tx_data=0; both FIFOs empty.
  - Pending-mode flag cleared; idle counter=0; both tx FSMs in IDLE.
  - Reset mid-transfer discards all FIFO contents.
- Modes and order: FORWARD(0001) -> SUB0_BLOCK1(0010) -> SUB1_BLOCK0(0100) -> ROT13(1000) -> FORWARD.
- Per-byte transform, applied at enqueue using the mode active in that cycle:
  - FORWARD: both directions unchanged.
  - SUB0_BLOCK1: if0 bytes become SUB_BYTE before going to if1; if1 bytes are dropped.
  - SUB1_BLOCK0: if1 bytes become SUB_BYTE before going to if0; if0 bytes are dropped.
  - ROT13: both directions. 8'h41-8'h5A and 8'h61-8'h7A are rotated by 13 within their case. All other values pass unchanged.
- FIFOs (FIFO A: if0 rx -> if1 tx; FIFO B: if1 rx -> if0 tx):
  - A rx_valid enqueues on the same edge.
  - Simultaneous if0/if1 rx_valid: both enqueue independently.
  - Full FIFO: the new byte is dropped and overflow is set (sticky until rst).
  - Enqueue and dequeue in the same cycle on a full FIFO: both occur, no drop.
  - Pointers wrap modulo FIFO_DEPTH.
  - Dropped-by-mode bytes are not enqueued.
- Tx FSM, one per direction:
  - IDLE: if FIFO non-empty and tx_ready=1, pulse tx_start for 1 cycle with tx_data=head, pop, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_ready=1, then go to IDLE.
  - tx_data holds its last value after a pulse.
  - Latency: rx_valid at edge n (FIFO empty, tx_ready=1) gives tx_start high in the cycle after edge n+1.
- Session tracking:
  - Any rx_valid (including mode-dropped bytes) sets comm_active and reloads the counter to IDLE_TIMEOUT_CYCLES.
  - The counter decrements each cycle while nonzero.
  - comm_active clears in the cycle where counter==0, both FIFOs are empty and both FSMs are in IDLE.
- Mode changes:
  - mode_next while comm_active=0: mode advances on that edge.
  - mode_next while comm_active=1: sets the pending flag. Additional presses while pending are ignored (at most one advance per session).
  - Pending is applied on the edge where comm_active falls, then cleared.
  - mode_next arriving in the same cycle as an rx_valid that starts a session: the mode advances, and that byte uses the old mode.

Test Plan:
- Reset, FORWARD: if0 rx 8'hCA -> if1_tx_start with 8'hCA two cycles later; if1 rx 8'hF1 -> if0_tx 8'hF1; mode_leds=0001.
- mode_next while idle -> 0010. Then if0 8'h9B -> if1_tx 8'h3F; simultaneous if0 8'h38 / if1 8'h26 -> if1_tx 8'h3F only, no if0_tx_start. comm_active falls IDLE_TIMEOUT_CYCLES after the last rx.
- mode_next mid-session in 0010, twice -> mode stays 0010 until comm_active falls, then becomes 0100 (a single advance).
- ROT13: if0 8'h5A -> if1 8'h4D; if1 8'h68 -> if0 8'h75; if0 8'h61 -> if1 8'h6E; if1 8'hCA -> if0 8'hCA.
- Hold if1_tx_ready=0 and send 6 bytes on if0 with FIFO_DEPTH=4 -> 4 bytes kept, overflow=1. After releasing ready, exactly the 4 bytes go out in order, each waiting for the ready low->high cycle.
- Assert rst with 3 bytes queued -> the FIFO is emptied, no further tx_start, mode_leds=0001, overflow=0, comm_active=0.
